// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file with pending-write scoreboard.
// Other files pull these in with import regfile_pkg::*.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int PEND_W_DEF = 2;

  // x0 is hardwired to zero and never takes part in hazard tracking.
  localparam int REG_ZERO = 0;

  // Largest count a PEND_W-bit pending counter may hold.
  function automatic int pend_limit(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb. master = pipeline, slave = register file.
// issue_valid/issue_ready: a reservation of issue_rd takes effect when both are high in the
// same cycle and flush is low; issue_valid may be dropped or retargeted freely when not accepted.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;

  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            flush;
  logic            wb_err;

  modport master (
    output rs1_addr, rs2_addr, issue_valid, issue_rd,
           wb_valid, wb_rd, wb_data, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, issue_valid, issue_rd,
           wb_valid, wb_rd, wb_data, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, wb_err
  );

endinterface

// File: rtl/regfile_sb_read_port.sv
// One combinational read port: x0 forcing, same-cycle writeback bypass and busy
// derived from the pending-write count of the addressed register.
module regfile_sb_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = 5,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic [AW-1:0]     addr,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [PEND_W-1:0] pend,
  output logic [XLEN-1:0]   data,
  output logic              busy
);

  localparam logic [AW-1:0]     ZERO_A   = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic wb_hit;

  assign wb_hit = wb_valid && (wb_rd == addr);

  always_comb begin
    data = reg_data;
    busy = (pend != '0);
    if (addr == ZERO_A) begin
      data = '0;
      busy = 1'b0;
    end else if (wb_hit) begin
      data = wb_data;
      // The arriving writeback retires the only outstanding write, so the value is final.
      if (pend == PEND_ONE) begin
        busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass and per-register pending-write counters.
// Decode reads two sources and reserves a destination; writeback commits data and releases it.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int PEND_W = PEND_W_DEF,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam logic [AW-1:0]     ZERO_A   = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_limit(PEND_W));
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              wb_err_q;
  logic              wb_err_d;

  logic              wb_to_reg;
  logic              issue_ready;
  logic              issue_acc;
  logic [NREGS-1:0]  inc_vec;
  logic [NREGS-1:0]  dec_vec;

  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;

  assign wb_to_reg = bus.wb_valid && (bus.wb_rd != ZERO_A);

  // A full counter can still accept a reservation when a writeback to it lands this cycle.
  assign issue_ready = (bus.issue_rd == ZERO_A)
                    || (pend_q[bus.issue_rd] != PEND_MAX)
                    || (bus.wb_valid && (bus.wb_rd == bus.issue_rd));
  assign issue_acc   = bus.issue_valid && issue_ready && !bus.flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_vec[r] = issue_acc && (bus.issue_rd == AW'(r));
      dec_vec[r] = bus.wb_valid && (bus.wb_rd == AW'(r)) && (pend_q[r] != '0);
    end
  end

  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.flush) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    pend_d[0] = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_to_reg) begin
      regs_d[bus.wb_rd] = bus.wb_data;
    end
    regs_d[0] = '0;
  end

  // Flush squashes the error check too: the pending counters are being discarded anyway.
  assign wb_err_d = wb_err_q
                 || (wb_to_reg && (pend_q[bus.wb_rd] == '0) && !bus.flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      pend_q   <= '{default: '0};
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
    end
  end

  regfile_sb_read_port #(
    .XLEN   (XLEN),
    .AW     (AW),
    .PEND_W (PEND_W)
  ) u_rd_port1 (
    .addr     (bus.rs1_addr),
    .wb_valid (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .reg_data (regs_q[bus.rs1_addr]),
    .pend     (pend_q[bus.rs1_addr]),
    .data     (rs1_data),
    .busy     (rs1_busy)
  );

  regfile_sb_read_port #(
    .XLEN   (XLEN),
    .AW     (AW),
    .PEND_W (PEND_W)
  ) u_rd_port2 (
    .addr     (bus.rs2_addr),
    .wb_valid (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .reg_data (regs_q[bus.rs2_addr]),
    .pend     (pend_q[bus.rs2_addr]),
    .data     (rs2_data),
    .busy     (rs2_busy)
  );

  assign bus.rs1_data    = rs1_data;
  assign bus.rs2_data    = rs2_data;
  assign bus.rs1_busy    = rs1_busy;
  assign bus.rs2_busy    = rs2_busy;
  assign bus.issue_ready = issue_ready;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a table of per-cycle vectors through a scoreboard queue, then an
// asynchronous mid-cycle reset sequence and a short randomised issue/writeback sequence.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int EXP_W = 2 * XLEN + 4;

  typedef struct {
    logic            rst;
    logic [AW-1:0]   r1;
    logic [AW-1:0]   r2;
    logic            iv;
    logic [AW-1:0]   ird;
    logic            wv;
    logic [AW-1:0]   wrd;
    logic [XLEN-1:0] wd;
    logic            fl;
    logic [XLEN-1:0] e_d1;
    logic [XLEN-1:0] e_d2;
    logic            e_b1;
    logic            e_b2;
    logic            e_rdy;
    logic            e_err;
  } vec_t;

  logic clk;
  logic rst;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .PEND_W (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rst_i, input int r1, input int r2,
                             input logic iv, input int ird,
                             input logic wv, input int wrd, input logic [XLEN-1:0] wd,
                             input logic fl,
                             input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                             input logic b1, input logic b2, input logic rdy, input logic err);
    vec_t t;
    t.rst = rst_i;  t.r1 = AW'(r1);  t.r2 = AW'(r2);
    t.iv  = iv;     t.ird = AW'(ird);
    t.wv  = wv;     t.wrd = AW'(wrd); t.wd = wd;  t.fl = fl;
    t.e_d1 = d1;    t.e_d2 = d2;
    t.e_b1 = b1;    t.e_b2 = b2;     t.e_rdy = rdy; t.e_err = err;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    rst             = t.rst;
    bus.rs1_addr    = t.r1;
    bus.rs2_addr    = t.r2;
    bus.issue_valid = t.iv;
    bus.issue_rd    = t.ird;
    bus.wb_valid    = t.wv;
    bus.wb_rd       = t.wrd;
    bus.wb_data     = t.wd;
    bus.flush       = t.fl;
  endtask

  // Drive one cycle's inputs, sample the outputs on the falling edge, advance past the rising edge.
  task automatic apply(input string tag, input vec_t t);
    logic [EXP_W-1:0] e;
    drive(t);
    exp_q.push_back({t.e_d1, t.e_d2, t.e_b1, t.e_b2, t.e_rdy, t.e_err});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".rs1_data"},    bus.rs1_data,           e[EXP_W-1 -: XLEN]);
    check({tag, ".rs2_data"},    bus.rs2_data,           e[XLEN+3 -: XLEN]);
    check({tag, ".rs1_busy"},    XLEN'(bus.rs1_busy),    XLEN'(e[3]));
    check({tag, ".rs2_busy"},    XLEN'(bus.rs2_busy),    XLEN'(e[2]));
    check({tag, ".issue_ready"}, XLEN'(bus.issue_ready), XLEN'(e[1]));
    check({tag, ".wb_err"},      XLEN'(bus.wb_err),      XLEN'(e[0]));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t            tbl [27];
  logic [XLEN-1:0] mdl [NREGS];

  initial begin
    //          rst r1 r2 iv ird wv wrd wdata          fl  d1             d2            b1 b2 rdy err
    tbl[0]  = v(0,  5, 0, 0, 0,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[1]  = v(0,  7, 0, 1, 7,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[2]  = v(0,  7, 0, 0, 0,  0, 0,  32'h0,         0,  32'h0,         32'h0,        1, 0, 1, 0);
    tbl[3]  = v(0,  7, 7, 0, 0,  1, 7,  32'hDEADBEEF,  0,  32'hDEADBEEF,  32'hDEADBEEF, 0, 0, 1, 0);
    tbl[4]  = v(0,  7, 0, 0, 0,  0, 0,  32'h0,         0,  32'hDEADBEEF,  32'h0,        0, 0, 1, 0);
    tbl[5]  = v(0,  0, 7, 0, 0,  1, 0,  32'h12345678,  0,  32'h0,         32'hDEADBEEF, 0, 0, 1, 0);
    tbl[6]  = v(0,  0, 0, 1, 0,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[7]  = v(0,  0, 0, 0, 0,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[8]  = v(0,  3, 0, 1, 3,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[9]  = v(0,  3, 0, 1, 3,  0, 0,  32'h0,         0,  32'h0,         32'h0,        1, 0, 1, 0);
    tbl[10] = v(0,  3, 0, 1, 3,  0, 0,  32'h0,         0,  32'h0,         32'h0,        1, 0, 1, 0);
    tbl[11] = v(0,  3, 0, 1, 3,  0, 0,  32'h0,         0,  32'h0,         32'h0,        1, 0, 0, 0);
    tbl[12] = v(0,  3, 0, 1, 3,  1, 3,  32'h33,        0,  32'h33,        32'h0,        1, 0, 1, 0);
    tbl[13] = v(0,  3, 0, 0, 0,  1, 3,  32'h34,        0,  32'h34,        32'h0,        1, 0, 1, 0);
    tbl[14] = v(0,  3, 0, 0, 0,  1, 3,  32'h35,        0,  32'h35,        32'h0,        1, 0, 1, 0);
    tbl[15] = v(0,  3, 0, 0, 0,  1, 3,  32'h36,        0,  32'h36,        32'h0,        0, 0, 1, 0);
    tbl[16] = v(0,  3, 0, 0, 0,  0, 0,  32'h0,         0,  32'h36,        32'h0,        0, 0, 1, 0);
    tbl[17] = v(0,  9, 0, 1, 9,  0, 0,  32'h0,         0,  32'h0,         32'h0,        0, 0, 1, 0);
    tbl[18] = v(0,  9, 0, 1, 10, 0, 0,  32'h0,         0,  32'h0,         32'h0,        1, 0, 1, 0);
    tbl[19] = v(0,  9, 10,0, 0,  1, 9,  32'h55,        1,  32'h55,        32'h0,        0, 1, 1, 0);
    tbl[20] = v(0,  9, 10,0, 0,  0, 0,  32'h0,         0,  32'h55,        32'h0,        0, 0, 1, 0);
    tbl[21] = v(0,  6, 0, 0, 0,  1, 6,  32'h66,        1,  32'h66,        32'h0,        0, 0, 1, 0);
    tbl[22] = v(0,  4, 6, 0, 0,  1, 4,  32'hA5,        0,  32'hA5,        32'h66,       0, 0, 1, 0);
    tbl[23] = v(0,  4, 9, 0, 0,  0, 0,  32'h0,         0,  32'hA5,        32'h55,       0, 0, 1, 1);
    tbl[24] = v(0,  4, 0, 1, 12, 0, 0,  32'h0,         0,  32'hA5,        32'h0,        0, 0, 1, 1);
    tbl[25] = v(0,  12,0, 0, 0,  1, 12, 32'h77,        0,  32'h77,        32'h0,        0, 0, 1, 1);
    tbl[26] = v(0,  8, 4, 1, 8,  0, 0,  32'h0,         0,  32'h0,         32'hA5,       0, 0, 1, 1);

    drive(v(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 1, 0));
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset raised between edges must clear state without a clock edge; the in-flight wb is lost.
    bus.rs1_addr = AW'(8);
    bus.rs2_addr = AW'(9);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = AW'(4);
    bus.wb_data  = 32'hFF;
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.rs1_busy", XLEN'(bus.rs1_busy), '0);
    check("async_rst.rs2_data", bus.rs2_data, '0);
    check("async_rst.wb_err",   XLEN'(bus.wb_err), '0);
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.wb_valid = 1'b0;
    bus.rs1_addr = AW'(4);
    bus.rs2_addr = AW'(3);
    #1;
    check("post_rst.rs1_data", bus.rs1_data, '0);
    check("post_rst.rs2_data", bus.rs2_data, '0);
    check("post_rst.wb_err",   XLEN'(bus.wb_err), '0);
    @(posedge clk);
    #1;

    // Randomised reserve / observe busy / writeback with bypass / read back from storage.
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    for (int i = 0; i < 8; i++) begin
      int k;
      int o;
      logic [XLEN-1:0] d;
      k = $urandom_range(1, NREGS - 1);
      o = (k % (NREGS - 1)) + 1;
      d = $urandom;
      apply($sformatf("rnd%0d.issue", i),
            v(0, k, o, 1, k, 0, 0, 32'h0, 0, mdl[k], mdl[o], 0, 0, 1, 0));
      apply($sformatf("rnd%0d.busy", i),
            v(0, k, o, 0, 0, 0, 0, 32'h0, 0, mdl[k], mdl[o], 1, 0, 1, 0));
      apply($sformatf("rnd%0d.wb", i),
            v(0, k, o, 0, 0, 1, k, d,     0, d,      mdl[o], 0, 0, 1, 0));
      mdl[k] = d;
      apply($sformatf("rnd%0d.read", i),
            v(0, o, k, 0, 0, 0, 0, 32'h0, 0, mdl[o], mdl[k], 0, 0, 1, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
